// File: rtl/canny_ddr3_pkg.sv
// Shared types and default widths for the two-port DDR3 arbiter.
package canny_ddr3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    WAIT_RD = 2'd3
  } arb_state_e;

  localparam int DDR3_AW = 32;
  localparam int DDR3_DW = 32;

endpackage

// File: rtl/ddr3_port_arbiter_rr_arb2.sv
// Two-way round-robin grant decision; the pointer only moves when a grant is taken.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_en_i,
  output logic grant_idx_o,
  output logic grant_valid_o
);

  logic last_q, last_d;

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_idx_o   = (req0_i && req1_i) ? ~last_q : req1_i;
    last_d        = grant_en_i ? grant_idx_o : last_q;
  end

  // Reset value claims m1 was served last, so m0 wins the first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Two-master DDR3 bridge arbiter: one transaction in flight, round-robin grants.
// Define DDR3_ARB_TIMEOUT_EN to add the completion-timeout watchdog.
module ddr3_port_arbiter
  import canny_ddr3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AW = DDR3_AW,
  parameter int DW = DDR3_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_done,
  output logic          m1_done,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] sdram_address,
  output logic          rd_en,
  output logic          wr_en,
  output logic [DW-1:0] write_data_input,
  input  logic [DW-1:0] read_data,
  input  logic          write_complete,
  input  logic          read_complete,
  output logic          busy,
  output logic          err_timeout
);

  arb_state_e    state_q, state_d;
  logic          gnt_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          arb_idx, arb_valid, grant_en;
  logic          in_wait, rd_hit, wr_hit, timeout_hit, finish;

  rr_arb2 u_rr_arb2 (
    .clock        (clock),
    .reset        (reset),
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .grant_en_i   (grant_en),
    .grant_idx_o  (arb_idx),
    .grant_valid_o(arb_valid)
  );

  assign grant_en = (state_q == IDLE) && arb_valid;
  assign in_wait  = (state_q == WAIT_WR) || (state_q == WAIT_RD);
  assign wr_hit   = (state_q == WAIT_WR) && write_complete;
  assign rd_hit   = (state_q == WAIT_RD) && read_complete;
  assign finish   = wr_hit | rd_hit | timeout_hit;

`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // A real completion in the same cycle as expiry wins over the timeout.
  assign timeout_hit = in_wait && !wr_hit && !rd_hit && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = in_wait ? cnt_q + CW'(1) : '0;
  assign err_d       = err_q | timeout_hit;
  assign err_timeout = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = ISSUE;
      ISSUE:   state_d = we_q ? WAIT_WR : WAIT_RD;
      WAIT_WR,
      WAIT_RD: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done0_d  = finish && !gnt_q;
    done1_d  = finish &&  gnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (rd_hit) begin
      if (gnt_q) rdata1_d = read_data;
      else       rdata0_d = read_data;
    end else if (timeout_hit) begin
      if (gnt_q) rdata1_d = '0;
      else       rdata0_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      if (grant_en) begin
        gnt_q   <= arb_idx;
        we_q    <= arb_idx ? m1_we    : m0_we;
        addr_q  <= arb_idx ? m1_addr  : m0_addr;
        wdata_q <= arb_idx ? m1_wdata : m0_wdata;
      end
    end
  end

  // Bridge-facing command lines are only non-zero during the single ISSUE cycle.
  assign sdram_address    = (state_q == ISSUE) ? addr_q  : '0;
  assign write_data_input = (state_q == ISSUE) ? wdata_q : '0;
  assign wr_en            = (state_q == ISSUE) &&  we_q;
  assign rd_en            = (state_q == ISSUE) && !we_q;
  assign busy             = (state_q != IDLE);
  assign m0_done          = done0_q;
  assign m1_done          = done1_q;
  assign m0_rdata         = rdata0_q;
  assign m1_rdata         = rdata1_q;

endmodule
